// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-side bus controller.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_IO_DATA,
        RGN_IO_RB,
        RGN_UNMAPPED
    } region_t;

    localparam logic [31:0] IO_OFS_DATA     = 32'd0;
    localparam logic [31:0] IO_OFS_RB       = 32'd1;
    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;
    localparam int          WAIT_CNT_W      = 3;

endpackage

// File: rtl/mem_bus_ctrl_port_sync.sv
// Two-flop synchronizer for an asynchronous multi-bit input bus.
module port_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: decodes core accesses to RAM, the I/O port or an
// unmapped error, with programmable wait states and a four-phase handshake.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int          ADDR_W      = 9,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic [31:0]       iMemAddr,
    input  logic [31:0]       iMemData,
    output logic [31:0]       oMemData,
    output logic              oMemRdy,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic              oRamWe,
    output logic [31:0]       oRamWData,
    input  logic [31:0]       iRamRData,
    input  logic [31:0]       iPORT,
    output logic [31:0]       oPORT,
    output logic              oBusErr
);

    state_t                state;
    region_t               rgn_q;
    logic                  wr_q;
    logic [31:0]           wdata_q;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  acc_ph;
    logic [31:0]           port_s;
    logic [31:0]           rd_sel;
    logic                  strobe;

    port_sync #(.WIDTH(32)) u_port_sync (
        .clk (iClk),
        .rst (iRst),
        .d   (iPORT),
        .q   (port_s)
    );

    function automatic region_t decode(input logic [31:0] a);
        if ((a >> ADDR_W) == 32'd0)
            return RGN_RAM;
        else if (a == IO_BASE + IO_OFS_DATA)
            return RGN_IO_DATA;
        else if (a == IO_BASE + IO_OFS_RB)
            return RGN_IO_RB;
        else
            return RGN_UNMAPPED;
    endfunction

    assign strobe = iMemRead | iMemWrite;

    always_comb begin
        rd_sel = 32'd0;
        case (rgn_q)
            RGN_RAM:     rd_sel = iRamRData;
            RGN_IO_DATA: rd_sel = port_s;
            RGN_IO_RB:   rd_sel = oPORT;
            default:     rd_sel = 32'd0;
        endcase
    end

    // ACCESS spans two cycles: the RAM address is presented from capture, so
    // read data is valid in the second cycle; the write strobe fires there too.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= ST_IDLE;
            rgn_q     <= RGN_UNMAPPED;
            wr_q      <= 1'b0;
            wdata_q   <= 32'd0;
            wait_cnt  <= '0;
            acc_ph    <= 1'b0;
            oMemData  <= 32'd0;
            oMemRdy   <= 1'b0;
            oRamAddr  <= '0;
            oRamWe    <= 1'b0;
            oRamWData <= 32'd0;
            oPORT     <= 32'd0;
            oBusErr   <= 1'b0;
        end else begin
            oRamWe  <= 1'b0;
            oBusErr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (strobe) begin
                        rgn_q   <= decode(iMemAddr);
                        wr_q    <= iMemWrite;
                        wdata_q <= iMemData;
                        acc_ph  <= 1'b0;
                        if (decode(iMemAddr) == RGN_RAM) begin
                            oRamAddr <= iMemAddr[ADDR_W-1:0];
                            if (iMemWrite)
                                oRamWData <= iMemData;
                        end
                        if (WAIT_STATES > 0) begin
                            wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
                            state    <= ST_WAIT;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0)
                        state <= ST_ACCESS;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                ST_ACCESS: begin
                    if (!acc_ph) begin
                        acc_ph <= 1'b1;
                        oRamWe <= (rgn_q == RGN_RAM) && wr_q;
                    end else begin
                        state   <= ST_DONE;
                        oMemRdy <= 1'b1;
                        oBusErr <= (rgn_q == RGN_UNMAPPED);
                        if (!wr_q)
                            oMemData <= rd_sel;
                        if (wr_q && rgn_q == RGN_IO_DATA)
                            oPORT <= wdata_q;
                    end
                end
                ST_DONE: begin
                    if (!strobe) begin
                        state   <= ST_IDLE;
                        oMemRdy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Memory-side bus controller directly downstream of the processor core. Consumes the core's read/write strobes, address and write data, and decodes each access to on-chip synchronous RAM, a memory-mapped I/O port or an unmapped error. Returns read data and the `iMemRdy` handshake the core's control unit waits on. Owns the external output port register and the input port synchronizer.

## Interface
Parameters:
- `ADDR_W`, 9: RAM word-address width; RAM occupies word addresses 0 .. 2^ADDR_W-1.
- `WAIT_STATES`, 1: extra cycles inserted before every access; legal range 0-7.
- `IO_BASE`, 32'hFFFF_FF00: word address of the port data register. `IO_BASE+1` is the port readback register.

Ports:
- `iClk`  in  1  clock; all logic on the rising edge.
- `iRst`  in  1  reset, asynchronous, active-high.
- `iMemRead`  in  1  read strobe from the core.
- `iMemWrite`  in  1  write strobe from the core.
- `iMemAddr`  in  32  word address from the core.
- `iMemData`  in  32  write data from the core.
- `oMemData`  out  32  registered read data to the core.
- `oMemRdy`  out  1  transaction-complete handshake to the core.
- `oRamAddr`  out  ADDR_W  RAM address.
- `oRamWe`  out  1  RAM write enable.
- `oRamWData`  out  32  RAM write data.
- `iRamRData`  in  32  RAM read data; valid one cycle after the address is presented.
- `iPORT`  in  32  asynchronous external input port.
- `oPORT`  out  32  external output port register.
- `oBusErr`  out  1  one-cycle pulse on completion of an unmapped access.

## Operation
- The FSM has four states: IDLE, WAIT, ACCESS, DONE.
- **IDLE**
  - If `iMemRead` or `iMemWrite` is high, latch address, write data and op.
  - If both strobes are high, the op is a write.
  - Go to WAIT if `WAIT_STATES`>0, else to ACCESS.
- **WAIT**
  - A 3-bit counter loads `WAIT_STATES-1` on entry and decrements each cycle.
  - At 0, go to ACCESS.
- **ACCESS** acts on the latched address; the decode is exclusive.
  - RAM region: drive `oRamAddr` = addr[ADDR_W-1:0]. On a write, also drive `oRamWData` and assert `oRamWe` for exactly this cycle.
  - `IO_BASE`: a write loads `oPORT`; a read selects synchronized `iPORT`.
  - `IO_BASE+1`: a read selects `oPORT`; a write is ignored.
  - Any other address is unmapped: a read returns 0 and a write is ignored.
  - Always go to DONE.
- **DONE**
  - On entry, `oMemData` is loaded with the selected read data. On a write it holds its previous value.
  - `oMemRdy`=1. `oBusErr`=1 on the entry cycle only, if the access was unmapped.
  - Stay in DONE while either strobe is high (four-phase handshake). Return to IDLE on the first cycle both strobes are low.
- Strobe, address or data changes after IDLE capture are ignored until the next IDLE.
- If the strobes drop before DONE is reached, the transaction still completes. DONE then lasts one cycle (`oMemRdy` pulses once) and the FSM goes to IDLE.
- `iPORT` passes through a two-flop synchronizer before use.

## Timing
- Reset values: state IDLE; `oMemRdy`, `oRamWe`, `oBusErr`=0; `oMemData`, `oPORT`, `oRamAddr`, `oRamWData`, synchronizer flops=0.
- Latency: strobe sampled high at edge T0 → `oMemRdy` high after edge T0+WAIT_STATES+2. Reads and writes have the same latency.
- `oPORT` updates at the ACCESS→DONE edge, i.e. in the same cycle `oMemRdy` rises.
- The earliest possible next transaction is captured on the edge after the strobes are seen low in DONE.
- Reset mid-transaction aborts it immediately: no RAM write completes after `iRst` asserts.
- `iPORT` is read with 2-cycle synchronizer lag: a value change must precede ACCESS by ≥2 cycles to be read.

## Structure
- Package `mem_bus_pkg`:
  - FSM state enum.
  - IO register offsets (0 = port data, 1 = port readback).
  - Default `IO_BASE`.
  - Wait-counter width constant.
- One sub-module, `port_sync`: a parameterized-width two-flop synchronizer with async active-high reset, used for `iPORT`.
- Decode, FSM and output registers live in `mem_bus_ctrl`.

## Test plan
- RAM write then read, WAIT_STATES=1:
  - Write 32'hDEADBEEF to address 5 → `oRamWe` high exactly 1 cycle with `oRamAddr`=5; `oMemRdy` 3 cycles after capture.
  - Read address 5 → `oMemData`=32'hDEADBEEF with `oMemRdy`.
- Port: write 32'h0000_00A5 to `IO_BASE` → `oPORT`=32'hA5 in the `oMemRdy` cycle. Read `IO_BASE+1` → 32'hA5. Hold `iPORT`=32'h1234 and read `IO_BASE` → 32'h1234.
- Unmapped read at 32'h0001_0000 → `oMemData`=0, `oBusErr` one-cycle pulse, `oRamWe` never asserted.
- Handshake:
  - Strobe held 4 cycles after rdy → `oMemRdy` stays high 5 cycles, then IDLE.
  - Strobe dropped 1 cycle after capture → single-cycle `oMemRdy`.
- Both strobes high on address 7 with data 32'h55 → treated as a write; RAM[7]=32'h55.
- `iRst` asserted during WAIT of a write → `oRamWe` never pulses, all outputs return to 0, and a following read of that address returns the old data.
